// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// constants_pkg / alu_sequencer
//
// Purpose:
//   Instruction-level controller for the alu_registers datapath. Accepts
//   16-bit micro-instructions over a valid/ready handshake. Each one is
//   decoded into the registered addr/data/op sequence the register file and
//   ALU need. Every operation is held for its required number of cycles.
//   Register reads come back as a one-cycle rd_valid pulse.
//
//   Instruction word: [15:14] opcode, [13:11] rd, [10:8] ra, [7:5] rb,
//   [7:0] imm.  00 LOAD r[rd]=imm, 01 ADD r[rd]=r[ra]+r[rb] (mod 256),
//   10 READ r[ra], 11 reserved (consumed, illegal pulsed).
//
// Parameters:
//   ADD_CYCLES    cycles op=ADD is held per ADD instruction (1..15)
//   READ_LATENCY  datapath read latency in cycles (0..3)
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   instr_valid   instruction present on instr
//   instr         instruction word
//   instr_ready   sequencer can accept (state == IDLE)
//   busy          state != IDLE
//   illegal       one-cycle pulse after a reserved opcode is accepted
//   rd_valid      one-cycle pulse, rd_data/rd_reg valid
//   rd_data       captured register value
//   rd_reg        register index of rd_data
//   addr_a/b/r    datapath register addresses (registered)
//   data_in       datapath write data (registered)
//   op            datapath operation (registered)
//   reg_data_out  datapath data_out
// ---------------------------------------------------------------------------

package constants_pkg;
    typedef enum logic [1:0] {
        REG_READ  = 2'd0,
        REG_WRITE = 2'd1,
        ADD       = 2'd2
    } ALUOp;
endpackage

module alu_sequencer #(
    parameter int ADD_CYCLES   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                instr_ready,
    output logic                busy,
    output logic                illegal,
    output logic                rd_valid,
    output logic [7:0]          rd_data,
    output logic [2:0]          rd_reg,
    output logic [2:0]          addr_a,
    output logic [2:0]          addr_b,
    output logic [2:0]          addr_r,
    output logic [7:0]          data_in,
    output constants_pkg::ALUOp op,
    input  logic [7:0]          reg_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ADD, S_READ} state_e;
    typedef enum logic [1:0] {OPC_LOAD, OPC_ADD, OPC_READ, OPC_RSVD} opcode_e;

    localparam logic [3:0] ADD_CNT = 4'(ADD_CYCLES);
    localparam logic [3:0] RD_CNT  = 4'(1 + READ_LATENCY);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    constants_pkg::ALUOp op_q, op_d;
    logic [2:0]          addr_a_q, addr_a_d;
    logic [2:0]          addr_b_q, addr_b_d;
    logic [2:0]          addr_r_q, addr_r_d;
    logic [7:0]          data_in_q, data_in_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic [2:0]          rd_reg_q, rd_reg_d;
    logic                rd_valid_q, rd_valid_d;
    logic                illegal_q, illegal_d;

    opcode_e    opcode;
    logic [2:0] f_rd, f_ra, f_rb;
    logic [7:0] f_imm;
    logic       accept;
    logic       last;

    assign opcode = opcode_e'(instr[15:14]);
    assign f_rd   = instr[13:11];
    assign f_ra   = instr[10:8];
    assign f_rb   = instr[7:5];
    assign f_imm  = instr[7:0];

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign accept      = instr_valid && instr_ready;
    // ADD and READ share one down-counter; the final cycle is when it reads 1.
    assign last        = (cnt_q == 4'd1);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= constants_pkg::REG_READ;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_r_q   <= '0;
            data_in_q  <= '0;
            rd_data_q  <= '0;
            rd_reg_q   <= '0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            addr_r_q   <= addr_r_d;
            data_in_q  <= data_in_d;
            rd_data_q  <= rd_data_d;
            rd_reg_q   <= rd_reg_d;
            rd_valid_q <= rd_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state logic, including the hold counter.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // assignment would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OPC_LOAD: state_d = S_WRITE;
                        OPC_ADD: begin
                            state_d = S_ADD;
                            cnt_d   = ADD_CNT;
                        end
                        OPC_READ: begin
                            state_d = S_READ;
                            cnt_d   = RD_CNT;
                        end
                        default: state_d = S_IDLE;  // reserved: consumed in place
                    endcase
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ADD, S_READ: begin
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered datapath/result outputs.
    // Addresses and data_in only change on acceptance, so they hold in IDLE.
    always_comb begin
        op_d       = op_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        addr_r_d   = addr_r_q;
        data_in_d  = data_in_q;
        rd_data_d  = rd_data_q;
        rd_reg_d   = rd_reg_q;
        rd_valid_d = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OPC_LOAD: begin
                            op_d      = constants_pkg::REG_WRITE;
                            addr_a_d  = f_rd;
                            data_in_d = f_imm;
                        end
                        OPC_ADD: begin
                            op_d     = constants_pkg::ADD;
                            addr_a_d = f_ra;
                            addr_b_d = f_rb;
                            addr_r_d = f_rd;
                        end
                        OPC_READ: begin
                            op_d     = constants_pkg::REG_READ;
                            addr_a_d = f_ra;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_WRITE: op_d = constants_pkg::REG_READ;
            S_ADD: begin
                if (last) op_d = constants_pkg::REG_READ;
            end
            S_READ: begin
                // addr_a still holds ra for the whole READ state.
                if (last) begin
                    rd_data_d  = reg_data_out;
                    rd_reg_d   = addr_a_q;
                    rd_valid_d = 1'b1;
                end
            end
            default: op_d = constants_pkg::REG_READ;
        endcase
    end

    assign op       = op_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign addr_r   = addr_r_q;
    assign data_in  = data_in_q;
    assign rd_data  = rd_data_q;
    assign rd_reg   = rd_reg_q;
    assign rd_valid = rd_valid_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. A small behavioural register file with a
// READ_LATENCY-deep read pipeline stands in for alu_registers. Outputs are
// sampled on the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------

module tb_alu_sequencer;

    localparam int N  = 3;  // ADD_CYCLES
    localparam int RL = 1;  // READ_LATENCY

    logic                clk = 1'b0;
    logic                reset_n;
    logic                instr_valid;
    logic [15:0]         instr;
    logic                instr_ready;
    logic                busy;
    logic                illegal;
    logic                rd_valid;
    logic [7:0]          rd_data;
    logic [2:0]          rd_reg;
    logic [2:0]          addr_a, addr_b, addr_r;
    logic [7:0]          data_in;
    constants_pkg::ALUOp op;
    logic [7:0]          reg_data_out;

    alu_sequencer #(.ADD_CYCLES(N), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .busy         (busy),
        .illegal      (illegal),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_reg       (rd_reg),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .addr_r       (addr_r),
        .data_in      (data_in),
        .op           (op),
        .reg_data_out (reg_data_out)
    );

    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [7:0] rf [8];
    logic [7:0] rd_pipe [4];

    always @(posedge clk) begin
        case (op)
            constants_pkg::REG_WRITE: rf[addr_a] <= data_in;
            constants_pkg::ADD:       rf[addr_r] <= rf[addr_a] + rf[addr_b];
            default: ;
        endcase
        rd_pipe[0] <= rf[addr_a];
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    generate
        if (RL == 0) begin : g_comb
            assign reg_data_out = rf[addr_a];
        end else begin : g_pipe
            assign reg_data_out = rd_pipe[RL-1];
        end
    endgenerate

    // ---------------- monitors ----------------
    int cyc = 0;
    int rd_count = 0;
    int ill_count = 0;
    int write_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_valid) rd_count <= rd_count + 1;
        if (illegal) ill_count <= ill_count + 1;
        if (op == constants_pkg::REG_WRITE) write_count <= write_count + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int acc_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_load(input logic [2:0] rd, input logic [7:0] imm);
        return {2'b00, rd, 3'b000, imm};
    endfunction

    function automatic logic [15:0] enc_add(input logic [2:0] rd, input logic [2:0] ra,
                                            input logic [2:0] rb);
        return {2'b01, rd, ra, rb, 5'b00000};
    endfunction

    function automatic logic [15:0] enc_read(input logic [2:0] ra);
        return {2'b10, 3'b000, ra, 8'h00};
    endfunction

    // Present a word, wait (bounded) for acceptance, and return at the falling
    // edge just after the accepting edge with instr_valid dropped. A following
    // send re-raises valid in the same time step, so valid looks held high.
    task automatic send(input logic [15:0] w);
        int n = 0;
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("send_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc     = cyc;
        instr_valid = 1'b0;
    endtask

    // READ ra and check the returned pulse, its timing and contents.
    task automatic read_expect(input logic [2:0] ra, input logic [7:0] exp);
        int n = 0;
        send(enc_read(ra));
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_seen", 32'(rd_valid), 32'd1);
        check("rd_latency", 32'(cyc - acc_cyc), 32'(1 + RL));
        check("rd_reg", 32'(rd_reg), 32'(ra));
        check("rd_data", 32'(rd_data), 32'(exp));
        @(negedge clk);
        check("rd_pulse_width", 32'(rd_valid), 32'd0);
    endtask

    logic [7:0] fib [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0d};

    initial begin
        int n;
        int a0;
        int rc0, ic0, wc0;

        instr_valid = 1'b0;
        instr       = '0;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        check("rst_op", 32'(op), 32'(constants_pkg::REG_READ));
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'({addr_a, addr_b, addr_r}), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_rd", 32'({rd_valid, rd_reg, rd_data}), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- basic sum ----
        send(enc_load(3'd0, 8'h42));
        check("load_op", 32'(op), 32'(constants_pkg::REG_WRITE));
        check("load_addr_a", 32'(addr_a), 32'd0);
        check("load_data_in", 32'(data_in), 32'h42);
        check("load_ready_low", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("load_op_back", 32'(op), 32'(constants_pkg::REG_READ));
        check("load_ready_back", 32'(instr_ready), 32'd1);
        check("load_data_hold", 32'(data_in), 32'h42);

        send(enc_load(3'd1, 8'h24));
        send(enc_add(3'd2, 3'd0, 3'd1));
        check("add_addrs", 32'({addr_a, addr_b, addr_r}), 32'({3'd0, 3'd1, 3'd2}));
        n = 0;
        while (op == constants_pkg::ADD && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("add_hold_cycles", 32'(n), 32'(N));
        check("add_ready_after", 32'(instr_ready), 32'd1);

        read_expect(3'd0, 8'h42);
        read_expect(3'd1, 8'h24);
        read_expect(3'd2, 8'h66);

        // ---- Fibonacci ----
        send(enc_load(3'd0, 8'h00));
        send(enc_load(3'd1, 8'h01));
        send(enc_load(3'd2, 8'h01));
        for (int r = 3; r < 8; r++) send(enc_add(3'(r), 3'(r - 2), 3'(r - 1)));
        for (int r = 0; r < 8; r++) read_expect(3'(r), fib[r]);

        // ---- wrap and throughput ----
        // Accepts at T0 (LOAD), T0+2 (LOAD), T0+4 (ADD), T0+5+N (READ);
        // rd_valid rises at T0+6+N+RL.
        send(enc_load(3'd0, 8'hFF));
        a0 = acc_cyc;
        send(enc_load(3'd1, 8'h01));
        send(enc_add(3'd2, 3'd0, 3'd1));
        send(enc_read(3'd2));
        n = 0;
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wrap_rd_valid", 32'(rd_valid), 32'd1);
        check("wrap_span", 32'(cyc - a0), 32'(6 + N + RL));
        check("wrap_data", 32'(rd_data), 32'h00);
        check("wrap_reg", 32'(rd_reg), 32'd2);
        @(negedge clk);

        // ---- reserved opcode ----
        ic0 = ill_count;
        send(16'hC000);
        check("rsvd_illegal", 32'(illegal), 32'd1);
        check("rsvd_op", 32'(op), 32'(constants_pkg::REG_READ));
        check("rsvd_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check("rsvd_illegal_pulse", 32'(illegal), 32'd0);
        check("rsvd_ready2", 32'(instr_ready), 32'd1);
        read_expect(3'd1, 8'h01);
        check("rsvd_ill_count", 32'(ill_count - ic0), 32'd1);

        // ---- reset mid-ADD ----
        send(enc_add(3'd4, 3'd5, 3'd6));
        check("midadd_op", 32'(op), 32'(constants_pkg::ADD));
        instr       = enc_read(3'd2);
        instr_valid = 1'b1;
        rc0         = rd_count;
        #2 reset_n  = 1'b0;
        #1;
        check("arst_op", 32'(op), 32'(constants_pkg::REG_READ));
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_addr", 32'({addr_a, addr_b, addr_r}), 32'd0);
        check("arst_rd_reg", 32'(rd_reg), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        instr_valid = 1'b0;
        reset_n     = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_rd_valid", 32'(rd_count - rc0), 32'd0);
        send(enc_load(3'd5, 8'h5A));
        read_expect(3'd5, 8'h5A);

        // ---- backpressure ----
        wc0 = write_count;
        rc0 = rd_count;
        send(enc_read(3'd1));
        instr       = enc_load(3'd6, 8'h11);
        instr_valid = 1'b1;
        @(negedge clk);
        instr = enc_load(3'd6, 8'h77);
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_rd_count", 32'(rd_count - rc0), 32'd1);
        check("bp_rd_data", 32'(rd_data), 32'h01);
        check("bp_write_once", 32'(write_count - wc0), 32'd1);
        read_expect(3'd6, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
